// File: rtl/cdb_broadcast_arb_if.sv
// rtl/cdb_broadcast_arb_if.sv - completion/CDB bus bundle between FUs and the broadcast arbiter
interface cdb_broadcast_arb_if #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 7,
    parameter int DATA_W = 64
);
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]        fu_done;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*DATA_W-1:0] fu_value;
    logic                     squash;
    logic [NUM_FU-1:0]        fu_stall;
    logic                     CAM_en;
    logic [TAG_W-1:0]         CDB_in;
    logic [DATA_W-1:0]        cdb_value;
    logic [IDX_W-1:0]         cdb_fu;

    modport master (
        output fu_done, fu_tag, fu_value, squash,
        input  fu_stall, CAM_en, CDB_in, cdb_value, cdb_fu
    );

    modport slave (
        input  fu_done, fu_tag, fu_value, squash,
        output fu_stall, CAM_en, CDB_in, cdb_value, cdb_fu
    );
endinterface

// File: rtl/cdb_broadcast_arb.sv
// rtl/cdb_broadcast_arb.sv - per-FU completion FIFOs with round-robin CDB broadcast; optional CDB_BYPASS_EN
module cdb_broadcast_arb #(
    parameter int NUM_FU    = 4,
    parameter int TAG_W     = 7,
    parameter int DATA_W    = 64,
    parameter int BUF_DEPTH = 2
) (
    input logic                clock,
    input logic                reset,
    cdb_broadcast_arb_if.slave bus
);
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [TAG_W-1:0] NULL_TAG = {TAG_W{1'b1}};
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    logic [TAG_W-1:0]  r_tag_mem [NUM_FU][BUF_DEPTH];
    logic [DATA_W-1:0] r_val_mem [NUM_FU][BUF_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr  [NUM_FU];
    logic [PTR_W-1:0]  r_wr_ptr  [NUM_FU];
    logic [CNT_W-1:0]  r_count   [NUM_FU];
    logic [IDX_W-1:0]  r_rr_ptr;
    logic              r_cam_en;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_value;
    logic [IDX_W-1:0]  r_cdb_fu;

    logic [TAG_W-1:0]  w_in_tag   [NUM_FU];
    logic [DATA_W-1:0] w_in_val   [NUM_FU];
    logic [TAG_W-1:0]  w_head_tag [NUM_FU];
    logic [DATA_W-1:0] w_head_val [NUM_FU];
    logic [NUM_FU-1:0] w_stall;
    logic [NUM_FU-1:0] w_push_req;
    logic [NUM_FU-1:0] w_cand;
    logic [NUM_FU-1:0] w_push;
    logic [NUM_FU-1:0] w_pop;
    logic              w_grant_vld;
    logic [IDX_W-1:0]  w_grant_idx;
    logic [IDX_W:0]    w_scan_idx;
    logic              w_bypass;
    logic [TAG_W-1:0]  w_win_tag;
    logic [DATA_W-1:0] w_win_val;

    // Per-FU slicing, FIFO heads, stall (registered count only) and arbitration candidates
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            w_in_tag[i]   = bus.fu_tag[i*TAG_W +: TAG_W];
            w_in_val[i]   = bus.fu_value[i*DATA_W +: DATA_W];
            w_head_tag[i] = r_tag_mem[i][r_rd_ptr[i]];
            w_head_val[i] = r_val_mem[i][r_rd_ptr[i]];
            w_stall[i]    = (r_count[i] == FULL_CNT);
            // Null-tag completions are consumed without ever touching the FIFO
            w_push_req[i] = bus.fu_done[i] && !w_stall[i] && !bus.squash && (w_in_tag[i] != NULL_TAG);
`ifdef CDB_BYPASS_EN
            w_cand[i]     = (r_count[i] != '0) || w_push_req[i];
`else
            w_cand[i]     = (r_count[i] != '0);
`endif
        end
    end

    // Round-robin scan from rr_ptr; scanning farthest-first lets the nearest candidate win last
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        for (int off = NUM_FU - 1; off >= 0; off--) begin
            w_scan_idx = {1'b0, r_rr_ptr} + (IDX_W+1)'(off);
            if (w_scan_idx >= (IDX_W+1)'(NUM_FU))
                w_scan_idx = w_scan_idx - (IDX_W+1)'(NUM_FU);
            if (w_cand[w_scan_idx[IDX_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan_idx[IDX_W-1:0];
            end
        end
    end

    // Winner data selection and per-FIFO push/pop strobes
    always_comb begin
        w_bypass = 1'b0;
`ifdef CDB_BYPASS_EN
        // Winner with an empty FIFO can only have been picked for its incoming completion
        w_bypass = w_grant_vld && (r_count[w_grant_idx] == '0);
`endif
        w_win_tag = w_bypass ? w_in_tag[w_grant_idx] : w_head_tag[w_grant_idx];
        w_win_val = w_bypass ? w_in_val[w_grant_idx] : w_head_val[w_grant_idx];
        for (int i = 0; i < NUM_FU; i++) begin
            w_pop[i]  = w_grant_vld && !w_bypass && !bus.squash && (w_grant_idx == IDX_W'(i));
            w_push[i] = w_push_req[i] && !(w_bypass && (w_grant_idx == IDX_W'(i)));
        end
    end

    // FIFO storage, pointers and occupancy; squash flushes every FIFO
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (reset || bus.squash) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end else begin
                if (w_push[i]) begin
                    r_tag_mem[i][r_wr_ptr[i]] <= w_in_tag[i];
                    r_val_mem[i][r_wr_ptr[i]] <= w_in_val[i];
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                end
                if (w_pop[i])
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // CDB output registers and round-robin pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cam_en    <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_value <= '0;
            r_cdb_fu    <= '0;
            r_rr_ptr    <= '0;
        end else if (bus.squash) begin
            r_cam_en <= 1'b0;
            r_rr_ptr <= '0;
        end else if (w_grant_vld) begin
            r_cam_en    <= 1'b1;
            r_cdb_tag   <= w_win_tag;
            r_cdb_value <= w_win_val;
            r_cdb_fu    <= w_grant_idx;
            r_rr_ptr    <= (w_grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : w_grant_idx + IDX_W'(1);
        end else begin
            r_cam_en <= 1'b0;
        end
    end

    assign bus.fu_stall  = w_stall;
    assign bus.CAM_en    = r_cam_en;
    assign bus.CDB_in    = r_cdb_tag;
    assign bus.cdb_value = r_cdb_value;
    assign bus.cdb_fu    = r_cdb_fu;
endmodule

// File: tb/tb_cdb_broadcast_arb.sv
// tb/tb_cdb_broadcast_arb.sv - vector table, directed sequences and random run against a queue model
module tb_cdb_broadcast_arb;
    localparam int NF    = 4;
    localparam int TW    = 7;
    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam logic [TW-1:0] NULL_TAG = 7'h7F;

    logic clock;
    logic reset;

    cdb_broadcast_arb_if #(.NUM_FU(NF), .TAG_W(TW), .DATA_W(DW)) bus ();

    cdb_broadcast_arb #(.NUM_FU(NF), .TAG_W(TW), .DATA_W(DW), .BUF_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: one queue of {tag,value} per FU plus the broadcast registers
    logic [TW+DW-1:0] mq [NF][$];
    int               m_rr;
    logic             m_cam;
    logic [TW-1:0]    m_tag;
    logic [DW-1:0]    m_val;
    logic [1:0]       m_fu;

    typedef struct {
        logic        rst;
        logic        sq;
        logic [3:0]  done;
        logic [27:0] tags;
        logic [63:0] base;
        logic        e_cam;
        logic [6:0]  e_tag;
        logic [63:0] e_val;
        logic [1:0]  e_fu;
        logic [3:0]  e_stall;
    } vec_t;

    vec_t vt [12];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(logic rst, logic sq, logic [3:0] done, logic [27:0] tags, logic [63:0] base);
        reset        = rst;
        bus.squash   = sq;
        bus.fu_done  = done;
        bus.fu_tag   = tags;
        for (int i = 0; i < NF; i++)
            bus.fu_value[i*DW +: DW] = base + 64'(i);
    endtask

    function automatic logic [3:0] model_stall();
        logic [3:0] s;
        for (int i = 0; i < NF; i++)
            s[i] = (mq[i].size() == DEPTH);
        return s;
    endfunction

    task automatic model_edge();
        bit               acc [NF];
        int               win;
        int               k;
        bit               byp;
        logic [TW+DW-1:0] e;
        logic [TW-1:0]    t;
        if (reset) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            m_rr = 0; m_cam = 0; m_tag = '0; m_val = '0; m_fu = '0;
            return;
        end
        if (bus.squash) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            m_rr = 0; m_cam = 0;
            return;
        end
        for (int i = 0; i < NF; i++) begin
            t = bus.fu_tag[i*TW +: TW];
            acc[i] = bus.fu_done[i] && (mq[i].size() < DEPTH) && (t != NULL_TAG);
        end
        win = -1;
        for (int off = 0; off < NF; off++) begin
            k = (m_rr + off) % NF;
`ifdef CDB_BYPASS_EN
            if (win < 0 && (mq[k].size() > 0 || acc[k])) win = k;
`else
            if (win < 0 && mq[k].size() > 0) win = k;
`endif
        end
        byp = (win >= 0) && (mq[win].size() == 0);
        if (win >= 0) begin
            if (byp) e = {bus.fu_tag[win*TW +: TW], bus.fu_value[win*DW +: DW]};
            else     e = mq[win].pop_front();
            m_cam = 1;
            m_tag = e[TW+DW-1:DW];
            m_val = e[DW-1:0];
            m_fu  = 2'(win);
            m_rr  = (win + 1) % NF;
        end else begin
            m_cam = 0;
        end
        for (int i = 0; i < NF; i++)
            if (acc[i] && !(byp && i == win))
                mq[i].push_back({bus.fu_tag[i*TW +: TW], bus.fu_value[i*DW +: DW]});
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        chk("cam_en", 64'(bus.CAM_en), 64'(m_cam));
        chk("cdb_in", 64'(bus.CDB_in), 64'(m_tag));
        chk("cdb_value", bus.cdb_value, m_val);
        chk("cdb_fu", 64'(bus.cdb_fu), 64'(m_fu));
        chk("fu_stall", 64'(bus.fu_stall), 64'(model_stall()));
    endtask

    function automatic vec_t mk(logic rst, logic [3:0] done, logic [27:0] tags, logic [63:0] base,
                                logic e_cam, logic [6:0] e_tag, logic [63:0] e_val, logic [1:0] e_fu);
        vec_t v;
        v.rst = rst; v.sq = 1'b0; v.done = done; v.tags = tags; v.base = base;
        v.e_cam = e_cam; v.e_tag = e_tag; v.e_val = e_val; v.e_fu = e_fu; v.e_stall = 4'b0000;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [6:0] t3;
        bit acc0, acc3, saw_stall0, seen15;
        logic [6:0] seen [$];
        logic [27:0] rt;

        vt[0]  = mk(0, 4'b0010, {7'd0, 7'd0, 7'd3, 7'd0}, 64'h29,  0, 7'd0, 64'h0,   2'd0);
        vt[1]  = mk(0, 4'b0000, {7'd0, 7'd0, 7'd3, 7'd0}, 64'h29,  1, 7'd3, 64'h2A,  2'd1);
        vt[2]  = mk(0, 4'b0000, 28'd0,                    64'h0,   0, 7'd3, 64'h2A,  2'd1);
        vt[3]  = mk(1, 4'b0000, 28'd0,                    64'h0,   0, 7'd0, 64'h0,   2'd0);
        vt[4]  = mk(0, 4'b1111, {7'd7, 7'd6, 7'd5, 7'd4}, 64'h100, 0, 7'd0, 64'h0,   2'd0);
        vt[5]  = mk(0, 4'b0000, 28'd0,                    64'h0,   1, 7'd4, 64'h100, 2'd0);
        vt[6]  = mk(0, 4'b0000, 28'd0,                    64'h0,   1, 7'd5, 64'h101, 2'd1);
        vt[7]  = mk(0, 4'b0000, 28'd0,                    64'h0,   1, 7'd6, 64'h102, 2'd2);
        vt[8]  = mk(0, 4'b0000, 28'd0,                    64'h0,   1, 7'd7, 64'h103, 2'd3);
        vt[9]  = mk(0, 4'b0000, 28'd0,                    64'h0,   0, 7'd7, 64'h103, 2'd3);
        vt[10] = mk(0, 4'b1000, {7'h7F, 7'd0, 7'd0, 7'd0}, 64'h50, 0, 7'd7, 64'h103, 2'd3);
        vt[11] = mk(0, 4'b0000, 28'd0,                    64'h0,   0, 7'd7, 64'h103, 2'd3);

        // Reset held two cycles with every FU completing
        drive(1, 0, 4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, 64'h10);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_cam", 64'(bus.CAM_en), 64'd0);
            chk("rst_stall", 64'(bus.fu_stall), 64'd0);
            chk("rst_tag", 64'(bus.CDB_in), 64'd0);
        end
        drive(0, 0, 4'b0000, 28'd0, 64'h0);
        step();
        chk("post_rst_cam", 64'(bus.CAM_en), 64'd0);
        chk("post_rst_stall", 64'(bus.fu_stall), 64'd0);

`ifndef CDB_BYPASS_EN
        // Vector table: single completion, contention from rr_ptr=0, null tag
        for (int r = 0; r < 12; r++) begin
            drive(vt[r].rst, vt[r].sq, vt[r].done, vt[r].tags, vt[r].base);
            step();
            chk($sformatf("vec%0d_cam", r), 64'(bus.CAM_en), 64'(vt[r].e_cam));
            chk($sformatf("vec%0d_tag", r), 64'(bus.CDB_in), 64'(vt[r].e_tag));
            chk($sformatf("vec%0d_val", r), bus.cdb_value, vt[r].e_val);
            chk($sformatf("vec%0d_fu", r), 64'(bus.cdb_fu), 64'(vt[r].e_fu));
            chk($sformatf("vec%0d_stall", r), 64'(bus.fu_stall), 64'(vt[r].e_stall));
        end
`endif

        // Back-pressure: FU0 sends 8,9,10 while FU3 keeps completing
        drive(1, 0, 4'b0000, 28'd0, 64'h0);
        step();
        n0 = 0; t3 = 7'd11; saw_stall0 = 0; seen.delete();
        for (int c = 0; c < 60 && seen.size() < 3; c++) begin
            rt = 28'd0;
            rt[6:0]   = 7'(8 + n0);
            rt[27:21] = t3;
            drive(0, 0, {1'b1, 2'b00, (n0 < 3)}, rt, 64'(c) << 8);
            acc0 = (n0 < 3) && !bus.fu_stall[0];
            acc3 = !bus.fu_stall[3];
            step();
            if (acc0) n0++;
            if (acc3) t3 = t3 + 7'd1;
            if (bus.fu_stall[0]) saw_stall0 = 1;
            if (bus.CAM_en && bus.cdb_fu == 2'd0) seen.push_back(bus.CDB_in);
        end
        chk("bp_stall0_seen", 64'(saw_stall0), 64'd1);
        chk("bp_fu0_count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3)
            for (int k = 0; k < 3; k++)
                chk($sformatf("bp_order%0d", k), 64'(seen[k]), 64'(8 + k));
        drive(0, 0, 4'b0000, 28'd0, 64'h0);
        repeat (8) step();

        // Squash drops queued 12,13 (and 21) plus same-cycle 14
        drive(1, 0, 4'b0000, 28'd0, 64'h0);
        step();
        drive(0, 0, 4'b0111, {7'd0, 7'd12, 7'd21, 7'd20}, 64'h200);
        step();
        drive(0, 0, 4'b0100, {7'd0, 7'd13, 7'd0, 7'd0}, 64'h300);
        step();
        drive(0, 1, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd14}, 64'h400);
        step();
        chk("sq_cam", 64'(bus.CAM_en), 64'd0);
        chk("sq_stall", 64'(bus.fu_stall), 64'd0);
        drive(0, 0, 4'b0000, 28'd0, 64'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("sq_idle%0d_cam", c), 64'(bus.CAM_en), 64'd0);
        end
        seen15 = 0;
        drive(0, 0, 4'b0010, {7'd0, 7'd0, 7'd15, 7'd0}, 64'h500);
        step();
        if (bus.CAM_en && bus.CDB_in == 7'd15) seen15 = 1;
        drive(0, 0, 4'b0000, 28'd0, 64'h0);
        step();
        if (bus.CAM_en && bus.CDB_in == 7'd15) seen15 = 1;
        chk("sq_after_tag15", 64'(seen15), 64'd1);

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NF; i++)
                rt[i*7 +: 7] = ($urandom_range(0, 7) == 0) ? NULL_TAG : 7'($urandom_range(0, 126));
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 31) == 0),
                  4'($urandom), rt, {$urandom, $urandom});
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
